// File: rtl/psram_pkg.sv
// Shared constants, state encoding and address helper for the PSRAM responder.
package psram_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h02;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WDATA,
    RDATA,
    IGNORE
  } psram_resp_state_t;

  // Advance a burst address by one byte, wrapping inside a 2^pageBits page
  // while the bits above the page are held.
  function automatic logic [23:0] pageIncr(input logic [23:0] addr, input int pageBits);
    logic [23:0] mask;
    mask = 24'((25'd1 << pageBits) - 25'd1);
    return (addr & ~mask) | ((addr + 24'd1) & mask);
  endfunction

endpackage

// File: rtl/psram_model_mem.sv
// Byte array standing in for the PSRAM cells: one clocked write port, a
// combinational read port for the serial data path and one for the backdoor.
module psram_model_mem #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  writeEn,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [7:0]            writeData,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  output logic [7:0]            readData,
  input  logic [ADDR_WIDTH-1:0] dbgAddr,
  output logic [7:0]            dbgData
);

  // Contents survive reset on purpose, like the real device.
  logic [7:0] mem [0:(2**ADDR_WIDTH)-1];

  // Commit a completed byte on the edge that samples its last bit.
  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
  end

  assign readData = mem[readAddr];
  assign dbgData  = mem[dbgAddr];

endmodule

// File: rtl/psram_spi_responder.sv
// SPI PSRAM responder: decodes command, 24-bit address and data bits sampled
// on every rising clock edge, writes bytes into the model memory and returns
// read bytes MSB-first with no dummy cycles.
module psram_spi_responder
  import psram_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int PAGE_BITS      = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      chip_enable,
  input  logic                      serial_in,
  output logic                      serial_out,
  output logic                      busy,
  output logic                      cmd_error,
  input  logic [MEM_ADDR_WIDTH-1:0] dbg_addr,
  output logic [7:0]                dbg_data
);

  psram_resp_state_t state_q;
  logic [4:0]        bitCnt_q;
  logic [6:0]        shift_q;
  logic [7:0]        cmd_q;
  logic [23:0]       addr_q;
  logic              cmdError_q;

  logic [7:0]        shiftByte;
  logic [23:0]       addr_d;
  logic              lastByteBit;
  logic              lastAddrBit;
  logic              memWe;
  logic [7:0]        readByte;

  // The byte completed by the bit being sampled right now, and the address
  // the burst moves on to once that byte is done.
  assign shiftByte   = {shift_q, serial_in};
  assign addr_d      = pageIncr(addr_q, PAGE_BITS);
  assign lastByteBit = (bitCnt_q == 5'(CMD_BITS - 1));
  assign lastAddrBit = (bitCnt_q == 5'(ADDR_BITS - 1));
  assign memWe       = (state_q == WDATA) && !chip_enable && lastByteBit;

  psram_model_mem #(
    .ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_mem (
    .clk      (clk),
    .writeEn  (memWe),
    .writeAddr(addr_q[MEM_ADDR_WIDTH-1:0]),
    .writeData(shiftByte),
    .readAddr (addr_q[MEM_ADDR_WIDTH-1:0]),
    .readData (readByte),
    .dbgAddr  (dbg_addr),
    .dbgData  (dbg_data)
  );

  // Read data comes straight from the registered address so the first MSB is
  // already on the wire when the last address bit has just been taken.
  assign serial_out = (state_q == RDATA) ? readByte[3'd7 - bitCnt_q[2:0]] : 1'b0;
  assign busy       = (state_q != IDLE);
  assign cmd_error  = cmdError_q;

  // Transaction state machine; chip_enable high aborts any phase on the edge
  // that sees it, dropping a partially shifted write byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bitCnt_q   <= 5'd0;
      shift_q    <= 7'd0;
      cmd_q      <= 8'd0;
      addr_q     <= 24'd0;
      cmdError_q <= 1'b0;
    end else begin
      cmdError_q <= 1'b0;
      if (chip_enable) begin
        state_q  <= IDLE;
        bitCnt_q <= 5'd0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q  <= CMD;
            shift_q  <= {6'd0, serial_in};
            bitCnt_q <= 5'd1;
          end
          CMD: begin
            shift_q <= shiftByte[6:0];
            if (lastByteBit) begin
              bitCnt_q <= 5'd0;
              cmd_q    <= shiftByte;
              if ((shiftByte == CMD_WRITE) || (shiftByte == CMD_READ)) begin
                state_q <= ADDR;
              end else begin
                state_q    <= IGNORE;
                cmdError_q <= 1'b1;
              end
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
            end
          end
          ADDR: begin
            addr_q <= {addr_q[22:0], serial_in};
            if (lastAddrBit) begin
              bitCnt_q <= 5'd0;
              state_q  <= (cmd_q == CMD_WRITE) ? WDATA : RDATA;
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
            end
          end
          WDATA: begin
            shift_q <= shiftByte[6:0];
            if (lastByteBit) begin
              bitCnt_q <= 5'd0;
              addr_q   <= addr_d;
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
            end
          end
          RDATA: begin
            if (lastByteBit) begin
              bitCnt_q <= 5'd0;
              addr_q   <= addr_d;
            end else begin
              bitCnt_q <= bitCnt_q + 5'd1;
            end
          end
          IGNORE: begin
            state_q <= IGNORE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_psram_spi_responder.sv
// Self-checking bench for psram_spi_responder: directed write/read table,
// hand-written corner sequences and randomized bursts against a byte-array
// reference model.
module tb_psram_spi_responder;

  typedef logic [7:0] byteQ_t [$];

  typedef struct {
    logic [23:0] addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [9:0]  a0;
    logic [7:0]  e0;
    logic [9:0]  a1;
    logic [7:0]  e1;
  } wrVec_t;

  logic       clk;
  logic       reset;
  logic       chipEnable;
  logic       serialIn;
  logic       serialOut;
  logic       busy;
  logic       cmdError;
  logic [9:0] dbgAddr;
  logic [7:0] dbgData;

  int compared;
  int mismatched;
  int errPulses;

  logic lastSo;
  logic lastErr;
  logic lastBusy;

  logic [7:0] modelMem [0:1023];
  bit         known    [0:1023];

  psram_spi_responder #(
    .MEM_ADDR_WIDTH(10),
    .PAGE_BITS     (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chip_enable(chipEnable),
    .serial_in  (serialIn),
    .serial_out (serialOut),
    .busy       (busy),
    .cmd_error  (cmdError),
    .dbg_addr   (dbgAddr),
    .dbg_data   (dbgData)
  );

  // Free-running clock, which is also the SPI clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every cycle in which the error pulse is seen.
  initial errPulses = 0;
  always @(negedge clk) begin
    if (cmdError === 1'b1) errPulses = errPulses + 1;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared = compared + 1;
    if (act !== exp) begin
      mismatched = mismatched + 1;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Drive one bit at the falling edge, capture the outputs that the coming
  // rising edge will see, then wait for that rising edge.
  task automatic applyStimulus(input logic ce, input logic si);
    @(negedge clk);
    chipEnable = ce;
    serialIn   = si;
    lastSo     = serialOut;
    lastErr    = cmdError;
    lastBusy   = busy;
    @(posedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) applyStimulus(1'b0, b[i]);
  endtask

  task automatic sendAddr(input logic [23:0] a);
    for (int i = 23; i >= 0; i--) applyStimulus(1'b0, a[i]);
  endtask

  task automatic endTxn();
    applyStimulus(1'b1, 1'b0);
  endtask

  function automatic logic [23:0] nextAddr(input logic [23:0] a);
    return {a[23:10], 10'(a[9:0] + 10'd1)};
  endfunction

  task automatic doWrite(input logic [23:0] addr, input byteQ_t data);
    logic [23:0] a;
    a = addr;
    sendByte(8'h02);
    sendAddr(addr);
    foreach (data[i]) begin
      sendByte(data[i]);
      modelMem[a[9:0]] = data[i];
      known[a[9:0]]    = 1'b1;
      a = nextAddr(a);
    end
    endTxn();
  endtask

  task automatic readBytes(input int n, output byteQ_t got);
    logic [7:0] v;
    got = {};
    for (int k = 0; k < n; k++) begin
      for (int i = 7; i >= 0; i--) begin
        applyStimulus(1'b0, 1'($urandom_range(0, 1)));
        v[i] = lastSo;
      end
      got.push_back(v);
    end
  endtask

  task automatic doRead(input logic [23:0] addr, input int n, output byteQ_t got);
    sendByte(8'h0B);
    sendAddr(addr);
    readBytes(n, got);
    endTxn();
  endtask

  task automatic checkDbg(input string name, input logic [9:0] a, input logic [7:0] exp);
    @(negedge clk);
    dbgAddr = a;
    #1;
    checkOutput(name, {24'd0, dbgData}, {24'd0, exp});
  endtask

  // Compare a read burst against the reference model wherever it is defined.
  task automatic checkAgainstModel(input string name, input logic [23:0] addr, input byteQ_t got);
    logic [23:0] a;
    a = addr;
    foreach (got[i]) begin
      if (known[a[9:0]]) checkOutput(name, {24'd0, got[i]}, {24'd0, modelMem[a[9:0]]});
      a = nextAddr(a);
    end
  endtask

  initial begin
    wrVec_t      vecs [3];
    byteQ_t      got;
    byteQ_t      wq;
    logic [23:0] ra;
    int          n;
    int          errBefore;
    int          errAt;
    logic        soOr;
    logic        busyBefore;

    compared   = 0;
    mismatched = 0;
    foreach (known[i]) begin
      known[i]    = 1'b0;
      modelMem[i] = 8'h00;
    end

    vecs[0] = '{addr: 24'h000010, d0: 8'hA5, d1: 8'h3C, a0: 10'h010, e0: 8'hA5, a1: 10'h011, e1: 8'h3C};
    vecs[1] = '{addr: 24'h0003FF, d0: 8'h11, d1: 8'h22, a0: 10'h3FF, e0: 8'h11, a1: 10'h000, e1: 8'h22};
    vecs[2] = '{addr: 24'hABC3FE, d0: 8'h5A, d1: 8'hC3, a0: 10'h3FE, e0: 8'h5A, a1: 10'h3FF, e1: 8'hC3};

    reset      = 1'b1;
    chipEnable = 1'b1;
    serialIn   = 1'b0;
    dbgAddr    = 10'd0;
    repeat (3) @(negedge clk);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    checkOutput("rstErr", {31'd0, cmdError}, 32'd0);
    checkOutput("rstSo", {31'd0, serialOut}, 32'd0);
    reset = 1'b0;
    @(posedge clk);

    // Directed table: write two bytes, inspect via backdoor, read back.
    for (int v = 0; v < 3; v++) begin
      wq = {vecs[v].d0, vecs[v].d1};
      doWrite(vecs[v].addr, wq);
      checkDbg("tblDbg0", vecs[v].a0, vecs[v].e0);
      checkDbg("tblDbg1", vecs[v].a1, vecs[v].e1);
      doRead(vecs[v].addr, 2, got);
      checkOutput("tblRd0", {24'd0, got[0]}, {24'd0, vecs[v].e0});
      checkOutput("tblRd1", {24'd0, got[1]}, {24'd0, vecs[v].e1});
    end
    checkOutput("tblNoErr", errPulses, 0);

    // Unsupported command: one error pulse right after bit 0, nothing driven.
    errBefore = errPulses;
    applyStimulus(1'b0, 1'b1);
    busyBefore = lastBusy;
    applyStimulus(1'b0, 1'b0);
    checkOutput("busyRise", {30'd0, busyBefore, lastBusy}, 32'b01);
    for (int i = 5; i >= 0; i--) applyStimulus(1'b0, (i == 4 || i == 3 || i == 2 || i == 1 || i == 0));
    errAt = -1;
    soOr  = 1'b0;
    for (int k = 0; k < 32; k++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)));
      if (lastErr === 1'b1 && errAt < 0) errAt = k;
      soOr = soOr | lastSo;
    end
    checkOutput("badBusy", {31'd0, lastBusy}, 32'd1);
    endTxn();
    checkOutput("badErrAt", errAt, 0);
    checkOutput("badErrCnt", errPulses - errBefore, 1);
    checkOutput("badSo", {31'd0, soOr}, 32'd0);
    checkDbg("badMem", 10'h010, 8'hA5);

    // Write aborted after four data bits leaves memory untouched.
    wq = {8'h77};
    doWrite(24'h000020, wq);
    sendByte(8'h02);
    sendAddr(24'h000020);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
    endTxn();
    checkOutput("abortBusyBefore", {31'd0, lastBusy}, 32'd1);
    @(negedge clk);
    checkOutput("abortBusyAfter", {31'd0, busy}, 32'd0);
    checkDbg("abortMem", 10'h020, 8'h77);

    // Reset in the middle of a read clears outputs at once.
    sendByte(8'h0B);
    sendAddr(24'h000010);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    @(negedge clk);
    checkOutput("midRdBit5", {31'd0, serialOut}, 32'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstMidSo", {31'd0, serialOut}, 32'd0);
    checkOutput("rstMidBusy", {31'd0, busy}, 32'd0);
    chipEnable = 1'b1;
    #2;
    reset = 1'b0;
    @(posedge clk);
    doRead(24'h000010, 2, got);
    checkOutput("postRst0", {24'd0, got[0]}, 32'hA5);
    checkOutput("postRst1", {24'd0, got[1]}, 32'h3C);

    // 32-byte burst across the page end, then read it back.
    wq = {};
    for (int i = 0; i < 32; i++) wq.push_back(8'($urandom));
    doWrite(24'h0003F0, wq);
    doRead(24'h0003F0, 32, got);
    checkAgainstModel("burst32", 24'h0003F0, got);

    // Randomized bursts, sometimes near the page end, checked by the model.
    for (int t = 0; t < 12; t++) begin
      ra = 24'($urandom);
      if ($urandom_range(0, 2) == 0) ra[9:0] = 10'(10'h3FA + 10'($urandom_range(0, 5)));
      n  = $urandom_range(1, 6);
      wq = {};
      for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
      doWrite(ra, wq);
      ra[23:10] = 14'($urandom);
      doRead(ra, n + 1, got);
      checkAgainstModel("rndRd", ra, got);
      checkDbg("rndDbg", ra[9:0], modelMem[ra[9:0]]);
    end
    checkOutput("totalErr", errPulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
